// File: rtl/dbuf_pkg.sv
// Shared types and constants for the dbuf read-side streaming path.
package dbuf_pkg;

    localparam int DBUF_DEPTH  = 49152;
    localparam int DBUF_ADDR_W = 16;
    localparam int DBUF_DATA_W = 32;
    localparam int DBUF_LEN_W  = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dbuf_state_e;

    typedef struct packed {
        logic                   last;
        logic [DBUF_DATA_W-1:0] data;
    } dbuf_beat_t;

    // Address step that wraps at the last real buffer word, not at the 16-bit limit.
    function automatic logic [DBUF_ADDR_W-1:0] dbuf_addr_inc(
        input logic [DBUF_ADDR_W-1:0] addr,
        input int                     depth
    );
        return (addr == DBUF_ADDR_W'(depth - 1)) ? {DBUF_ADDR_W{1'b0}} : addr + 16'd1;
    endfunction

endpackage

// File: rtl/dbuf_rd_stream_if.sv
// Valid/ready output stream carrying dbuf words with a last-beat marker.
interface dbuf_rd_stream_if;
    import dbuf_pkg::*;

    logic [DBUF_DATA_W-1:0] m_data;
    logic                   m_last;
    logic                   m_valid;
    logic                   m_ready;

    modport master (output m_data, output m_last, output m_valid, input m_ready);
    modport slave  (input m_data, input m_last, input m_valid, output m_ready);

endinterface

// File: rtl/dbuf_rd_fifo.sv
// Small synchronous FIFO of {last, data} beats; head is read straight from storage.
module dbuf_rd_fifo
    import dbuf_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  dbuf_beat_t       i_push_beat,
    input  logic             i_pop,
    output dbuf_beat_t       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    dbuf_beat_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Beat storage; cleared so the stream data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '{last: 1'b0, data: 32'h0000_0000};
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_push_beat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    dbuf_rd_fifo_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (i_push),
        .i_full (o_full)
    );

endmodule

// File: rtl/dbuf_rd_fifo_chk.sv
// Property checker for the output skid FIFO.
module dbuf_rd_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic i_push,
    input logic i_full
);

    // An overflow means the upstream credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && i_full));

endmodule

// File: rtl/dbuf_rd_stream.sv
// Walks a dbuf address range on command and streams the read words out with back-pressure.
module dbuf_rd_stream
    import dbuf_pkg::*;
#(
    parameter  int DEPTH      = DBUF_DEPTH,
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DBUF_ADDR_W-1:0] base,
    input  logic [DBUF_LEN_W-1:0]  len,
    output logic                   busy,
    output logic                   done,
    output logic [DBUF_ADDR_W-1:0] didx,
    output logic                   RW,
    input  logic [DBUF_DATA_W-1:0] di,
    dbuf_rd_stream_if.master       strm
);

    dbuf_state_e            r_state;
    dbuf_state_e            w_state_nxt;
    logic [DBUF_ADDR_W-1:0] r_addr;
    logic [DBUF_ADDR_W-1:0] r_didx;
    logic [DBUF_LEN_W-1:0]  r_rem;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_issue;
    logic                   r_issue_last;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_zero_job;
    logic                   w_finish;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    logic [CNT_W:0]         w_pending;
    dbuf_beat_t             w_head;
    dbuf_beat_t             w_push_beat;

    // Reads are two stages from issue to FIFO push (didx register, then dbuf register),
    // so both stages are reserved against FIFO space before issuing.
    assign w_pending   = {1'b0, w_count} + (CNT_W+1)'(r_issue) + (CNT_W+1)'(r_inflight);
    assign w_pop       = strm.m_valid & strm.m_ready;
    assign w_push_beat = '{last: r_inflight_last, data: di};

    // Next state and per-cycle command decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_accept    = 1'b0;
        w_zero_job  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (len != 17'd0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_zero_job  = start;
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if ((r_rem != 17'd0) && (w_pending < (CNT_W+1)'(FIFO_DEPTH)) && !w_full) begin
                    w_issue     = 1'b1;
                    w_state_nxt = (r_rem == 17'd1) ? DRAIN : RUN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head.last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, status flags and the read-latency pipeline tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_issue         <= 1'b0;
            r_issue_last    <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_done          <= w_finish | w_zero_job;
            r_issue         <= w_issue;
            r_issue_last    <= w_issue && (r_rem == 17'd1);
            r_inflight      <= r_issue;
            r_inflight_last <= r_issue_last;
            if (w_accept)      r_busy <= 1'b1;
            else if (w_finish) r_busy <= 1'b0;
        end
    end

    // Address and remaining-word counters; didx holds its value between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 16'd0;
            r_didx <= 16'd0;
            r_rem  <= 17'd0;
        end else if (w_accept) begin
            r_addr <= base;
            r_rem  <= len;
        end else if (w_issue) begin
            r_didx <= r_addr;
            r_addr <= dbuf_addr_inc(r_addr, DEPTH);
            r_rem  <= r_rem - 17'd1;
        end
    end

    dbuf_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign busy         = r_busy;
    assign done         = r_done;
    assign didx         = r_didx;
    assign RW           = 1'b0;
    assign strm.m_valid = ~w_empty;
    assign strm.m_data  = w_head.data;
    assign strm.m_last  = w_head.last;

endmodule

// File: tb/tb_dbuf_rd_stream.sv
// Scoreboard bench for dbuf_rd_stream against a registered-read dbuf model.
module tb_dbuf_rd_stream;
    import dbuf_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base  = 16'd0;
    logic [16:0] len   = 17'd0;
    logic        busy;
    logic        done;
    logic        RW;
    logic [15:0] didx;
    logic [31:0] di;

    dbuf_rd_stream_if strm ();

    logic [31:0] mem [0:DBUF_DEPTH-1];
    logic [32:0] exp_q [$];

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int exp_done  = 0;
    int hs_cnt    = 0;
    int max_cnt   = 0;
    bit rdy_rand  = 1'b0;

    always #5 clk = ~clk;

    dbuf_rd_stream #(
        .DEPTH      (DBUF_DEPTH),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .didx  (didx),
        .RW    (RW),
        .di    (di),
        .strm  (strm)
    );

    // dbuf model: one-cycle registered read.
    always @(posedge clk) di <= mem[didx];

    initial begin
        for (int i = 0; i < DBUF_DEPTH; i++) mem[i] = 32'(i) + 32'h0000_1000;
    end

    // Consumer ready: held high, or random when stalling is enabled.
    initial begin
        strm.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 strm.m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected beats on each handshake and checks stall/done rules.
    initial begin
        bit          prev_valid   = 1'b0;
        bit          prev_ready   = 1'b0;
        bit          prev_last_hs = 1'b0;
        logic [32:0] prev_beat    = 33'd0;
        logic [32:0] exp_beat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid   = 1'b0;
                prev_ready   = 1'b0;
                prev_last_hs = 1'b0;
            end else begin
                if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
                if (done) done_cnt++;
                if (prev_last_hs) begin
                    checks++;
                    if (!(done && !busy)) begin
                        failures++;
                        $display("FAIL done_after_last: done=%0b busy=%0b, required done=1 busy=0", done, busy);
                    end
                end
                if (prev_valid && !prev_ready) begin
                    checks++;
                    if (!strm.m_valid || ({strm.m_last, strm.m_data} != prev_beat)) begin
                        failures++;
                        $display("FAIL stall_stable: valid=%0b beat=%h, required valid=1 beat=%h",
                                 strm.m_valid, {strm.m_last, strm.m_data}, prev_beat);
                    end
                end
                prev_last_hs = 1'b0;
                if (strm.m_valid && strm.m_ready) begin
                    hs_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat: got %h, required no beat", {strm.m_last, strm.m_data});
                    end else begin
                        exp_beat = exp_q.pop_front();
                        if ({strm.m_last, strm.m_data} != exp_beat) begin
                            failures++;
                            $display("FAIL beat: got %h, required %h", {strm.m_last, strm.m_data}, exp_beat);
                        end
                    end
                    prev_last_hs = strm.m_last;
                end
                prev_valid = strm.m_valid;
                prev_ready = strm.m_ready;
                prev_beat  = {strm.m_last, strm.m_data};
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic kick(input logic [15:0] b, input logic [16:0] l);
        @(posedge clk);
        #1 base = b; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_range(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back({(i == l - 1), 32'((b + i) % DBUF_DEPTH) + 32'h0000_1000});
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((done_cnt < exp_done) && (n < 2000)) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check({name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int run;
        int n;
        int hs0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, RW, didx, strm.m_valid, strm.m_last, strm.m_data},
              64'd0);
        rst_n = 1'b1;

        // Basic job: latency, back-to-back beats, last marker.
        exp_q.push_back(33'h0_0000_100A);
        exp_q.push_back(33'h0_0000_100B);
        exp_q.push_back(33'h0_0000_100C);
        exp_q.push_back(33'h1_0000_100D);
        exp_done++;
        kick(16'd10, 17'd4);
        lat = 0;
        @(negedge clk);
        while (!strm.m_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("first_valid_latency", 64'(lat), 64'd3);
        run = 1;
        repeat (3) begin
            @(negedge clk);
            if (strm.m_valid) run++;
        end
        check("consecutive_beats", 64'(run), 64'd4);
        wait_done("basic");

        // Address wrap at DEPTH-1.
        exp_q.push_back(33'h0_0000_CFFE);
        exp_q.push_back(33'h0_0000_CFFF);
        exp_q.push_back(33'h0_0000_1000);
        exp_q.push_back(33'h1_0000_1001);
        exp_done++;
        kick(16'd49150, 17'd4);
        wait_done("wrap");

        // Zero-length job.
        exp_done++;
        kick(16'd5, 17'd0);
        @(negedge clk);
        check("zero_len_done", {done, busy}, 64'b10);
        run = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || strm.m_valid) run++;
        end
        check("zero_len_quiet", 64'(run), 64'd0);
        wait_done("zero_len");

        // Random back-pressure.
        rdy_rand = 1'b1;
        max_cnt  = 0;
        expect_range(200, 16);
        exp_done++;
        kick(16'd200, 17'd16);
        wait_done("stall");
        rdy_rand = 1'b0;
        check("fifo_count_bound", 64'(max_cnt <= 4), 64'd1);

        // Second start during RUN is ignored.
        expect_range(300, 6);
        exp_done++;
        kick(16'd300, 17'd6);
        kick(16'd1000, 17'd3);
        wait_done("restart_ignored");

        // Reset mid-job aborts with no done, then a fresh job runs.
        expect_range(100, 8);
        hs0 = hs_cnt;
        kick(16'd100, 17'd8);
        n = 0;
        while ((hs_cnt < hs0 + 3) && (n < 100)) begin
            @(posedge clk);
            n++;
        end
        check("abort_beats_seen", 64'(hs_cnt - hs0), 64'd3);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_outputs", {busy, done, RW, didx, strm.m_valid, strm.m_last, strm.m_data},
              64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(exp_done));
        exp_q.push_back(33'h0_0000_1000);
        exp_q.push_back(33'h1_0000_1001);
        exp_done++;
        kick(16'd0, 17'd2);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
